// File: rtl/nes_clk_pkg.sv
// Shared clock/reset sequencing types and NES timing defaults.
// Imported by the sequencer and by the PPU/CPU wrappers that consume its enables.
package nes_clk_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    PLL_RST   = 3'd4
  } nesClkState_e;

  localparam int NES_PHASES  = 7;
  localparam int NES_CPU_DIV = 3;

  // Width of a counter that only ever holds 0..bound-1; never narrower than one bit.
  function automatic int cntWidth(input int bound);
    return (bound > 1) ? $clog2(bound) : 1;
  endfunction

endpackage

// File: rtl/nes_sync2.sv
// Two-flop synchroniser with async active-low clear.
// Used both for the PLL lock input and for releasing the core reset.
module nes_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_clk_rst_seq.sv
// PLL lock filter, core reset sequencer and PPU/CPU clock-enable generator.
// Everything runs on the PLL output clock; all outputs come straight from flops.
module nes_clk_rst_seq
  import nes_clk_pkg::*;
#(
  parameter int LOCK_FILTER  = 1024,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 2**20,
  parameter int PLL_RST_LEN  = 8,
  parameter int PHASES       = NES_PHASES,
  parameter int CPU_DIV      = NES_CPU_DIV
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_pll_lock,
  output logic       o_pll_reset,
  output logic       o_sys_resetn,
  output logic       o_ppu_ce,
  output logic       o_cpu_ce,
  output logic [2:0] o_phase,
  output logic       o_ready
);

  localparam int FILT_W = cntWidth(LOCK_FILTER);
  localparam int HOLD_W = cntWidth(RST_HOLD);
  localparam int TO_W   = cntWidth(LOCK_TIMEOUT);
  localparam int PLL_W  = cntWidth(PLL_RST_LEN);
  localparam int CPU_W  = cntWidth(CPU_DIV);

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [PLL_W-1:0]  PLL_MAX  = PLL_W'(PLL_RST_LEN - 1);
  localparam logic [2:0]        PH_MAX   = 3'(PHASES - 1);
  localparam logic [CPU_W-1:0]  CPU_MAX  = CPU_W'(CPU_DIV - 1);

  logic w_rstN;
  logic w_lockS;

  // Reset asserts asynchronously but is released two clocks later, in step with the PLL clock.
  nes_sync2 u_rstSync (
    .i_clk  (i_clk),
    .i_rst_n(i_resetn),
    .i_d    (1'b1),
    .o_q    (w_rstN)
  );

  nes_sync2 u_lockSync (
    .i_clk  (i_clk),
    .i_rst_n(w_rstN),
    .i_d    (i_pll_lock),
    .o_q    (w_lockS)
  );

  nesClkState_e      r_state;
  nesClkState_e      w_nextState;
  logic [TO_W-1:0]   r_timer,    w_timerNext;
  logic [FILT_W-1:0] r_filtCnt,  w_filtNext;
  logic [HOLD_W-1:0] r_holdCnt,  w_holdNext;
  logic [PLL_W-1:0]  r_pllCnt,   w_pllNext;
  logic [2:0]        r_phase,    w_phaseNext;
  logic [CPU_W-1:0]  r_cpuPhase, w_cpuPhaseNext;
  logic              w_runNext;
  logic              r_pllReset;
  logic              r_sysResetn;
  logic              r_ready;
  logic              r_ppuCe;
  logic              r_cpuCe;

  // Each counter defaults to zero, so it restarts every time its state is left or re-entered.
  always_comb begin
    w_nextState = r_state;
    w_timerNext = '0;
    w_filtNext  = '0;
    w_holdNext  = '0;
    w_pllNext   = '0;
    case (r_state)
      WAIT_LOCK: begin
        if (w_lockS)                 w_nextState = FILTER;
        else if (r_timer == TO_MAX)  w_nextState = PLL_RST;
        else                         w_timerNext = r_timer + 1'b1;
      end
      FILTER: begin
        if (!w_lockS)                  w_nextState = WAIT_LOCK;
        else if (r_filtCnt == FILT_MAX) w_nextState = HOLD;
        else                           w_filtNext  = r_filtCnt + 1'b1;
      end
      HOLD: begin
        if (!w_lockS)                   w_nextState = WAIT_LOCK;
        else if (r_holdCnt == HOLD_MAX) w_nextState = RUN;
        else                            w_holdNext  = r_holdCnt + 1'b1;
      end
      RUN: begin
        if (!w_lockS) w_nextState = WAIT_LOCK;
      end
      PLL_RST: begin
        if (r_pllCnt == PLL_MAX) w_nextState = WAIT_LOCK;
        else                     w_pllNext   = r_pllCnt + 1'b1;
      end
      default: w_nextState = WAIT_LOCK;
    endcase
  end

  // Phase counters only move while staying in RUN, so entering RUN always starts at phase 0.
  always_comb begin
    w_runNext      = (w_nextState == RUN);
    w_phaseNext    = '0;
    w_cpuPhaseNext = '0;
    if (w_runNext && (r_state == RUN)) begin
      if (r_phase == PH_MAX) begin
        w_phaseNext    = '0;
        w_cpuPhaseNext = (r_cpuPhase == CPU_MAX) ? '0 : r_cpuPhase + 1'b1;
      end else begin
        w_phaseNext    = r_phase + 3'd1;
        w_cpuPhaseNext = r_cpuPhase;
      end
    end
  end

  always_ff @(posedge i_clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state     <= WAIT_LOCK;
      r_timer     <= '0;
      r_filtCnt   <= '0;
      r_holdCnt   <= '0;
      r_pllCnt    <= '0;
      r_phase     <= '0;
      r_cpuPhase  <= '0;
      r_pllReset  <= 1'b0;
      r_sysResetn <= 1'b0;
      r_ready     <= 1'b0;
      r_ppuCe     <= 1'b0;
      r_cpuCe     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_timer     <= w_timerNext;
      r_filtCnt   <= w_filtNext;
      r_holdCnt   <= w_holdNext;
      r_pllCnt    <= w_pllNext;
      r_phase     <= w_phaseNext;
      r_cpuPhase  <= w_cpuPhaseNext;
      r_pllReset  <= (w_nextState == PLL_RST);
      r_sysResetn <= w_runNext;
      r_ready     <= w_runNext;
      r_ppuCe     <= w_runNext && (w_phaseNext == PH_MAX);
      r_cpuCe     <= w_runNext && (w_phaseNext == PH_MAX) && (w_cpuPhaseNext == CPU_MAX);
    end
  end

  assign o_pll_reset  = r_pllReset;
  assign o_sys_resetn = r_sysResetn;
  assign o_ready      = r_ready;
  assign o_ppu_ce     = r_ppuCe;
  assign o_cpu_ce     = r_cpuCe;
  assign o_phase      = r_phase;

endmodule

// File: tb/tb_nes_clk_rst_seq.sv
// Randomised and directed bench for nes_clk_rst_seq against a streak-counting reference model.
module tb_nes_clk_rst_seq;

  localparam int LF      = 16;
  localparam int RH      = 4;
  localparam int LT      = 64;
  localparam int PRL     = 8;
  localparam int PHASES  = 7;
  localparam int CPU_DIV = 3;
  localparam int RUN_AT  = 1 + LF + RH;

  logic       clk = 1'b0;
  logic       i_resetn;
  logic       i_pll_lock;
  logic       o_pll_reset;
  logic       o_sys_resetn;
  logic       o_ppu_ce;
  logic       o_cpu_ce;
  logic [2:0] o_phase;
  logic       o_ready;

  nes_clk_rst_seq #(
    .LOCK_FILTER (LF),
    .RST_HOLD    (RH),
    .LOCK_TIMEOUT(LT),
    .PLL_RST_LEN (PRL),
    .PHASES      (PHASES),
    .CPU_DIV     (CPU_DIV)
  ) u_dut (
    .i_clk       (clk),
    .i_resetn    (i_resetn),
    .i_pll_lock  (i_pll_lock),
    .o_pll_reset (o_pll_reset),
    .o_sys_resetn(o_sys_resetn),
    .o_ppu_ce    (o_ppu_ce),
    .o_cpu_ce    (o_cpu_ce),
    .o_phase     (o_phase),
    .o_ready     (o_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: relEdges covers the reset release delay, ls1/ls2 the lock synchroniser,
  // streak the run of consecutive clean lock samples, zeroRun the no-lock wait time.
  int   relEdges = 0;
  logic ls1 = 1'b0;
  logic ls2 = 1'b0;
  int   streak = 0;
  int   zeroRun = 0;
  int   pllRemain = 0;

  int   cyc = 0;
  logic prevPll = 1'b0;
  logic prevSys = 1'b0;
  int   firstPllRise = -1;
  int   lastPllRise = -1;
  int   pllWidth = -1;
  int   pllPeriod = -1;
  int   sysRiseCyc = -1;
  int   cntPpu = 0;
  int   cntCpu = 0;
  int   cpuAlone = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic modelReset();
    relEdges  = 0;
    ls1       = 1'b0;
    ls2       = 1'b0;
    streak    = 0;
    zeroRun   = 0;
    pllRemain = 0;
  endtask

  task automatic modelStep(input logic lockIn);
    if (relEdges < 2) begin
      relEdges++;
    end else begin
      if (pllRemain > 0) begin
        pllRemain--;
      end else if (ls2) begin
        streak++;
        zeroRun = 0;
      end else if (streak > 0) begin
        streak  = 0;
        zeroRun = 0;
      end else begin
        zeroRun++;
        if (zeroRun == LT) begin
          pllRemain = PRL;
          zeroRun   = 0;
        end
      end
      ls2 = ls1;
      ls1 = lockIn;
    end
  endtask

  function automatic logic [7:0] expectedOutputs();
    logic       rdy;
    int         r;
    logic [2:0] ph;
    logic       p;
    logic       c;
    rdy = (streak >= RUN_AT);
    r   = rdy ? (streak - RUN_AT) : 0;
    ph  = rdy ? 3'(r % PHASES) : 3'd0;
    p   = rdy && ((r % PHASES) == PHASES - 1);
    c   = rdy && ((r % (PHASES * CPU_DIV)) == PHASES * CPU_DIV - 1);
    return {(pllRemain > 0), rdy, rdy, p, c, ph};
  endfunction

  task automatic applyStimulus(input logic lockVal, input int nCycles);
    for (int i = 0; i < nCycles; i++) begin
      i_pll_lock = lockVal;
      @(posedge clk);
      modelStep(lockVal);
      cyc++;
      @(negedge clk);
      checkOutput("outputs", 32'({o_pll_reset, o_sys_resetn, o_ready, o_ppu_ce, o_cpu_ce, o_phase}),
                  32'(expectedOutputs()));
      if (o_pll_reset && !prevPll) begin
        if (lastPllRise >= 0) pllPeriod = cyc - lastPllRise;
        if (firstPllRise < 0) firstPllRise = cyc;
        lastPllRise = cyc;
      end
      if (!o_pll_reset && prevPll) pllWidth = cyc - lastPllRise;
      if (o_sys_resetn && !prevSys) sysRiseCyc = cyc;
      prevPll = o_pll_reset;
      prevSys = o_sys_resetn;
      cntPpu += int'(o_ppu_ce);
      cntCpu += int'(o_cpu_ce);
      if (o_cpu_ce && !o_ppu_ce) cpuAlone++;
    end
  endtask

  task automatic doAsyncReset();
    #2 i_resetn = 1'b0;
    #1 checkOutput("asyncReset", 32'({o_pll_reset, o_sys_resetn, o_ready, o_ppu_ce, o_cpu_ce, o_phase}), 32'h0);
    modelReset();
    prevPll     = 1'b0;
    prevSys     = 1'b0;
    lastPllRise = -1;
    @(negedge clk);
    i_resetn = 1'b1;
  endtask

  task automatic waitForRun();
    int n;
    n = 0;
    while (streak < RUN_AT && n < 100) begin
      applyStimulus(1'b1, 1);
      n++;
    end
    checkOutput("runReached", 32'(streak >= RUN_AT), 32'd1);
  endtask

  initial begin
    int lockStart;
    int n;
    logic lv;
    int len;

    i_resetn   = 1'b0;
    i_pll_lock = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("porReset", 32'({o_pll_reset, o_sys_resetn, o_ready, o_ppu_ce, o_cpu_ce, o_phase}), 32'h0);
    i_resetn = 1'b1;
    modelReset();
    cyc = 0;

    $display("[TB] no lock: PLL reset pulses");
    applyStimulus(1'b0, 214);
    checkOutput("pllFirstRise", 32'(firstPllRise), 32'd66);
    checkOutput("pllWidth", 32'(pllWidth), 32'(PRL));
    checkOutput("pllPeriod", 32'(pllPeriod), 32'(LT + PRL));

    $display("[TB] lock held: sequence to RUN");
    applyStimulus(1'b1, 40);
    checkOutput("readyAfterLock", 32'(o_ready), 32'd1);

    $display("[TB] glitch during FILTER");
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 13);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 22);
    checkOutput("sysLowAfterGlitch", 32'(o_sys_resetn), 32'd0);
    applyStimulus(1'b1, 10);

    $display("[TB] lock loss in RUN and relock");
    waitForRun();
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 3);
    checkOutput("lossOutputs", 32'({o_ready, o_sys_resetn, o_ppu_ce, o_cpu_ce}), 32'h0);
    sysRiseCyc = -1;
    lockStart  = cyc;
    applyStimulus(1'b1, 30);
    checkOutput("relockLatency", 32'((sysRiseCyc - lockStart) >= 21 && (sysRiseCyc - lockStart) <= 23), 32'd1);

    $display("[TB] async reset mid-HOLD and mid-RUN");
    applyStimulus(1'b0, 3);
    n = 0;
    while (streak != LF + 2 && n < 60) begin
      applyStimulus(1'b1, 1);
      n++;
    end
    checkOutput("holdReached", 32'(streak), 32'(LF + 2));
    doAsyncReset();
    applyStimulus(1'b1, 40);
    waitForRun();
    applyStimulus(1'b1, 5);
    doAsyncReset();
    applyStimulus(1'b0, 5);
    applyStimulus(1'b1, 30);

    $display("[TB] enable counting over 2100 RUN cycles");
    waitForRun();
    n = streak - RUN_AT;
    applyStimulus(1'b1, 7 - ((n + 1) % 7 == 0 ? 7 : (n + 1) % 7) + 0);
    cntPpu   = 0;
    cntCpu   = 0;
    cpuAlone = 0;
    lockStart = streak;
    applyStimulus(1'b1, 2100);
    checkOutput("stayedInRun", 32'(streak - lockStart), 32'd2100);
    checkOutput("ppuCount", 32'(cntPpu), 32'd300);
    checkOutput("cpuCount", 32'(cntCpu), 32'd100);
    checkOutput("cpuWithoutPpu", 32'(cpuAlone), 32'd0);

    $display("[TB] random lock activity");
    for (int seg = 0; seg < 40; seg++) begin
      lv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) len = 80;
      applyStimulus(lv, len);
      if ($urandom_range(0, 15) == 0) doAsyncReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
